// File: rtl/wired_fpu_tag_wrap_pkg.sv
// Shared types for the FPU tag wrapper: IQ-side request/response, core-side request/response and tags.
// TAG_CNT lives here because every tagged struct width depends on it.
package wired_fpu_tag_wrap_pkg;

    localparam int TAG_CNT = 4;
    localparam int TAG_W   = $clog2(TAG_CNT);
    localparam int WID_W   = 5;
    localparam int OP_W    = 5;
    localparam int MODE_W  = 3;
    localparam int DATA_W  = 32;
    localparam int EXCP_W  = 5;

    typedef logic [TAG_W-1:0] fpu_tag_t;
    typedef logic [WID_W-1:0] rob_wid_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [MODE_W-1:0] mode;
        logic [DATA_W-1:0] r0;
        logic [DATA_W-1:0] r1;
        logic [DATA_W-1:0] r2;
        rob_wid_t          wid;
    } iq_fpu_req_t;

    typedef struct packed {
        rob_wid_t          wid;
        logic [DATA_W-1:0] result;
        logic [EXCP_W-1:0] fp_excp;
    } iq_fpu_resp_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [MODE_W-1:0] mode;
        logic [DATA_W-1:0] r0;
        logic [DATA_W-1:0] r1;
        logic [DATA_W-1:0] r2;
        fpu_tag_t          tag;
    } fpu_core_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [EXCP_W-1:0] fp_excp;
        fpu_tag_t          tag;
    } fpu_core_resp_t;

    // Index of the lowest clear bit; only meaningful when at least one bit is clear.
    function automatic fpu_tag_t lowest_free(input logic [TAG_CNT-1:0] valid);
        fpu_tag_t idx;
        idx = '0;
        for (int i = TAG_CNT - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                idx = fpu_tag_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wired_fpu_tag_wrap_alloc.sv
// Tag table for the FPU wrapper: per-tag valid/stale/wid, lowest-free allocation,
// flush stale marking and busy indication.
import wired_fpu_tag_wrap_pkg::*;

module wired_fpu_tag_alloc (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    input  logic     alloc_en,
    input  rob_wid_t alloc_wid,
    input  logic     free_en,
    input  fpu_tag_t free_tag,
    output fpu_tag_t alloc_tag,
    output logic     free_any,
    output logic     busy,
    output logic     lookup_valid,
    output logic     lookup_stale,
    output rob_wid_t lookup_wid
);

    logic [TAG_CNT-1:0] valid_reg;
    logic [TAG_CNT-1:0] valid_next;
    logic [TAG_CNT-1:0] stale_reg;
    logic [TAG_CNT-1:0] stale_next;
    logic [TAG_CNT-1:0] alloc_hit;
    logic [TAG_CNT-1:0] free_hit;
    rob_wid_t           wid_reg [TAG_CNT];

    // Allocation looks only at the pre-cycle valid vector, so a tag freed this
    // cycle can never be handed out again until the following cycle.
    assign alloc_tag = lowest_free(valid_reg);
    assign free_any  = |(~valid_reg);
    assign busy      = |valid_reg;

    assign lookup_valid = valid_reg[free_tag];
    assign lookup_stale = stale_reg[free_tag];
    assign lookup_wid   = wid_reg[free_tag];

    generate
        for (genvar gi = 0; gi < TAG_CNT; gi++) begin : g_tag
            // A return on a tag that is not valid is ignored, so it cannot
            // cancel an allocation landing on that same tag.
            assign free_hit[gi]  = free_en && (free_tag == fpu_tag_t'(gi)) && valid_reg[gi];
            assign alloc_hit[gi] = alloc_en && (alloc_tag == fpu_tag_t'(gi));

            always_comb begin
                valid_next[gi] = valid_reg[gi];
                stale_next[gi] = stale_reg[gi];
                if (free_hit[gi]) begin
                    valid_next[gi] = 1'b0;
                    stale_next[gi] = 1'b0;
                end else if (alloc_hit[gi]) begin
                    valid_next[gi] = 1'b1;
                    stale_next[gi] = 1'b0;
                end else if (flush && valid_reg[gi]) begin
                    stale_next[gi] = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (alloc_hit[gi]) begin
                    wid_reg[gi] <= alloc_wid;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
            stale_reg <= '0;
        end else begin
            valid_reg <= valid_next;
            stale_reg <= stale_next;
        end
    end

endmodule

// File: rtl/wired_fpu_tag_wrap.sv
// Tag wrapper between the FPU issue queue and an out-of-order-completing FPU core.
// Define WIRED_FPU_RESP_BYPASS_EN to forward live results to resp_o in the fire cycle when the output is free.
import wired_fpu_tag_wrap_pkg::*;

module wired_fpu_tag_wrap (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush_i,
    input  logic           req_valid_i,
    output logic           req_ready_o,
    input  iq_fpu_req_t    req_i,
    output logic           core_valid_o,
    input  logic           core_ready_i,
    output fpu_core_req_t  core_req_o,
    input  logic           core_valid_i,
    output logic           core_ready_o,
    input  fpu_core_resp_t core_resp_i,
    output logic           resp_valid_o,
    input  logic           resp_ready_i,
    output iq_fpu_resp_t   resp_o,
    output logic           busy_o
);

    fpu_tag_t     alloc_tag;
    logic         free_any;
    logic         busy;
    logic         tag_valid;
    logic         tag_stale;
    rob_wid_t     tag_wid;
    logic         req_fire;
    logic         core_fire;
    logic         tag_live;
    logic         bypass;
    logic         resp_load;
    logic         resp_valid_reg;
    iq_fpu_resp_t resp_reg;
    iq_fpu_resp_t resp_new;

    wired_fpu_tag_alloc u_alloc (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush_i),
        .alloc_en     (req_fire),
        .alloc_wid    (req_i.wid),
        .free_en      (core_fire),
        .free_tag     (core_resp_i.tag),
        .alloc_tag    (alloc_tag),
        .free_any     (free_any),
        .busy         (busy),
        .lookup_valid (tag_valid),
        .lookup_stale (tag_stale),
        .lookup_wid   (tag_wid)
    );

    assign core_valid_o = req_valid_i & free_any & ~flush_i;
    assign req_ready_o  = core_ready_i & free_any & ~flush_i;
    assign req_fire     = core_valid_o & core_ready_i;

    assign core_req_o.op   = req_i.op;
    assign core_req_o.mode = req_i.mode;
    assign core_req_o.r0   = req_i.r0;
    assign core_req_o.r1   = req_i.r1;
    assign core_req_o.r2   = req_i.r2;
    assign core_req_o.tag  = alloc_tag;

    // During flush every result is dropped, so the core may always drain.
    assign core_ready_o = ~resp_valid_reg | resp_ready_i | flush_i;
    assign core_fire    = core_valid_i & core_ready_o;
    assign tag_live     = core_fire & tag_valid & ~tag_stale & ~flush_i;

    assign resp_new.wid     = tag_wid;
    assign resp_new.result  = core_resp_i.result;
    assign resp_new.fp_excp = core_resp_i.fp_excp;

`ifdef WIRED_FPU_RESP_BYPASS_EN
    assign bypass       = tag_live & ~resp_valid_reg & resp_ready_i;
    assign resp_valid_o = resp_valid_reg | bypass;
    assign resp_o       = resp_valid_reg ? resp_reg : resp_new;
`else
    assign bypass       = 1'b0;
    assign resp_valid_o = resp_valid_reg;
    assign resp_o       = resp_reg;
`endif

    assign resp_load = tag_live & ~bypass;
    assign busy_o    = busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_reg <= 1'b0;
        end else if (flush_i) begin
            resp_valid_reg <= 1'b0;
        end else if (resp_load) begin
            resp_valid_reg <= 1'b1;
        end else if (resp_ready_i) begin
            resp_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (resp_load) begin
            resp_reg <= resp_new;
        end
    end

    // A core result on a tag that was never issued points at a broken core.
    always_ff @(posedge clk) begin
        if (!rst && core_fire) begin
            assert (tag_valid)
            else $error("wired_fpu_tag_wrap: core result on tag %0d which is not in flight", core_resp_i.tag);
        end
    end

endmodule
